rs_stream_encoder: RTL and testbench

//   Streaming systematic Reed-Solomon encoder over GF(2^8).
//   - Accepts message symbols one per beat on a valid/ready stream.
//   - Forwards each symbol unchanged, then appends NPAR parity symbols.
//   - Parity comes from an LFSR division by g(x) = prod_{i=0}^{NPAR-1} (x - alpha^(FCR+i)).
//   - Sits between the framer and the line interface. Successor to the fixed 64+4 parallel

---
 rtl/rs_stream_encoder.sv | 144 ++++++++++++++
 tb/tb_rs_stream_encoder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_stream_encoder.sv
// Streaming systematic Reed-Solomon encoder over GF(2^8), LFSR parity.
// Optional RS_ENC_SHORTEN_EN adds s_last for shortened messages.
module rs_stream_encoder #(
    parameter int          K    = 64,
    parameter int          NPAR = 4,
    parameter int          FCR  = 0,
    parameter logic [8:0]  PRIM = 9'h11D
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
`ifdef RS_ENC_SHORTEN_EN
    input  logic       s_last,
`endif
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_last
);

    localparam logic [7:0] POLY     = PRIM[7:0];
    localparam logic [7:0] CNT_LAST = 8'(K - 1);
    localparam logic [4:0] PAR_LAST = 5'(NPAR - 1);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ POLY) : (aa << 1);
        end
        return p;
    endfunction

    // Product of (x + alpha^(FCR+i)); the monic top term is dropped.
    function automatic logic [8*NPAR-1:0] gen_coefs();
        logic [7:0]          c [NPAR+1];
        logic [7:0]          root;
        logic [8*NPAR-1:0]   packed_g;
        root = 8'h01;
        for (int e = 0; e < FCR; e++) root = gf_mul(root, 8'h02);
        for (int j = 0; j <= NPAR; j++) c[j] = 8'h00;
        c[0] = 8'h01;
        for (int i = 0; i < NPAR; i++) begin
            for (int j = NPAR; j > 0; j--) c[j] = c[j-1] ^ gf_mul(c[j], root);
            c[0] = gf_mul(c[0], root);
            root = gf_mul(root, 8'h02);
        end
        packed_g = '0;
        for (int j = 0; j < NPAR; j++) packed_g[8*j +: 8] = c[j];
        return packed_g;
    endfunction

    localparam logic [8*NPAR-1:0] GEN = gen_coefs();

    typedef enum logic {S_MSG, S_PAR} state_t;

    state_t     state, state_nxt;
    logic [7:0] cnt;
    logic [4:0] pcnt;
    logic [7:0] par  [NPAR];
    logic [7:0] prod [NPAR];
    logic [7:0] fb;
    logic       adv;
    logic       accept;
    logic       emit;
    logic       msg_end;
    logic       par_end;

    assign adv     = !m_valid || m_ready;
    assign fb      = s_data ^ par[NPAR-1];
    assign par_end = (pcnt == PAR_LAST);

`ifdef RS_ENC_SHORTEN_EN
    assign msg_end = (cnt == CNT_LAST) || s_last;
`else
    assign msg_end = (cnt == CNT_LAST);
`endif

    // Feedback times each generator coefficient.
    always_comb begin
        for (int j = 0; j < NPAR; j++) prod[j] = gf_mul(fb, GEN[8*j +: 8]);
    end

    // Phase register: message pass-through, then parity drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_MSG;
        else        state <= state_nxt;
    end

    // Next phase, input handshake and accept/emit strobes.
    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        accept    = 1'b0;
        emit      = 1'b0;
        unique case (state)
            S_MSG: begin
                s_ready = adv && rst_n;
                accept  = s_valid && s_ready;
                if (accept && msg_end) state_nxt = S_PAR;
            end
            S_PAR: begin
                emit = adv;
                if (emit && par_end) state_nxt = S_MSG;
            end
            default: state_nxt = S_MSG;
        endcase
    end

    // Output register, counters and parity LFSR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 8'd0;
            pcnt    <= 5'd0;
            m_data  <= 8'h00;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            for (int j = 0; j < NPAR; j++) par[j] <= 8'h00;
        end else if (accept) begin
            m_data  <= s_data;
            m_valid <= 1'b1;
            m_last  <= 1'b0;
            par[0]  <= prod[0];
            for (int j = 1; j < NPAR; j++) par[j] <= par[j-1] ^ prod[j];
            cnt     <= msg_end ? 8'd0 : cnt + 8'd1;
        end else if (emit) begin
            m_data  <= par[NPAR-1];
            m_valid <= 1'b1;
            m_last  <= par_end;
            par[0]  <= 8'h00;
            for (int j = 1; j < NPAR; j++) par[j] <= par[j-1];
            pcnt    <= par_end ? 5'd0 : pcnt + 5'd1;
        end else if (adv) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rs_stream_encoder.sv
// Bench for rs_stream_encoder: polynomial-division model plus scoreboard.
// Directed codewords, stalls, mid-codeword reset and throughput.
module tb_rs_stream_encoder;

    localparam int K  = 64;
    localparam int NP = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic       s_last;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic       m_last;

    rs_stream_encoder #(.K(K), .NPAR(NP), .FCR(0), .PRIM(9'h11D)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_data (s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
`ifdef RS_ENC_SHORTEN_EN
        .s_last (s_last),
`endif
        .m_data (m_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_last (m_last)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int lg [256];
    int ex [512];
    int gd [5] = '{1, 15, 54, 120, 64};

    logic [7:0] msg_buf [0:254];
    logic [7:0] par_exp [0:3];
    logic [8:0] exp_q [$];
    int         len_q [$];
    int         lc [$];
    logic [39:0] hist = '0;

    bit  gap_en   = 0;
    bit  rdy_rand = 0;
    bit  tp_en    = 0;
    int  lowcnt   = 0;

    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return ex[lg[a] + lg[b]];
    endfunction

    // Remainder of m(x)*x^NP divided by g(x), by long division.
    task automatic model_parity(input int n);
        int r [0:259];
        int c;
        for (int i = 0; i < n + NP; i++) r[i] = (i < n) ? int'(msg_buf[i]) : 0;
        for (int i = 0; i < n; i++) begin
            c = r[i];
            if (c != 0)
                for (int j = 0; j <= NP; j++) r[i+j] = r[i+j] ^ gmul(c, gd[j]);
        end
        for (int j = 0; j < NP; j++) par_exp[j] = 8'(r[n+j]);
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1 m_ready = rdy_rand ? ($urandom_range(0, 9) < 7) : 1'b1;
    end

    logic       hold_v = 0;
    logic [7:0] hold_d;
    logic       hold_l;
    int         beats  = 0;
    logic [8:0] e;
    int         el;

    // Scoreboard: every accepted output beat and every stalled beat.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 0;
            beats  = 0;
        end else begin
            if (hold_v) begin
                checks++;
                if (!(m_valid && m_data == hold_d && m_last == hold_l)) begin
                    failures++;
                    $display("FAIL stall_hold got=%0b/%0h/%0b exp=1/%0h/%0b",
                             m_valid, m_data, m_last, hold_d, hold_l);
                end
            end
            hold_v = m_valid && !m_ready;
            hold_d = m_data;
            hold_l = m_last;
            if (tp_en && !s_ready && (lc.size() == 1 || lc.size() == 2)) lowcnt++;
            if (m_valid && m_ready) begin
                beats++;
                hist = {hist[31:0], m_data};
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL extra_beat got=%0h exp=none", m_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_last, m_data} !== e) begin
                        failures++;
                        $display("FAIL beat got=%0h exp=%0h", {m_last, m_data}, e);
                    end
                end
                if (m_last) begin
                    el = (len_q.size() != 0) ? len_q.pop_front() : -1;
                    checks++;
                    if (beats != el) begin
                        failures++;
                        $display("FAIL cw_len got=%0d exp=%0d", beats, el);
                    end
                    beats = 0;
                    lc.push_back(cyc);
                end
            end
        end
    end

    task automatic drive_sym(input logic [7:0] d, input logic lst);
        int w;
        int g;
        g = gap_en ? $urandom_range(0, 2) : 0;
        if (g > 0) begin
            s_valid = 1'b0;
            repeat (g) @(negedge clk);
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = lst;
        w = 0;
        while (!s_ready && w < 1000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 1000) begin
            checks++;
            failures++;
            $display("FAIL s_ready_timeout got=0 exp=1");
        end
        @(negedge clk);
    endtask

    task automatic send_msg(input int n, input bit full);
        if (full) model_parity(n);
        for (int i = 0; i < n; i++) exp_q.push_back({1'b0, msg_buf[i]});
        if (full) begin
            for (int j = 0; j < NP; j++) exp_q.push_back({j == NP - 1, par_exp[j]});
            len_q.push_back(n + NP);
        end
        for (int i = 0; i < n; i++) drive_sym(msg_buf[i], i == n - 1);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || m_valid) && w < 5000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 5000) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout got=%0d exp=0", exp_q.size());
        end
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) msg_buf[i] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int x;
        x = 1;
        for (int i = 0; i < 255; i++) begin
            ex[i] = x;
            lg[x] = i;
            x = x << 1;
            if (x & 256) x = x ^ 'h11D;
        end
        for (int i = 255; i < 512; i++) ex[i] = ex[i-255];
        lg[0] = 0;

        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data",  64'(m_data),  64'd0);
        chk("rst_m_last",  64'(m_last),  64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < K; i++) msg_buf[i] = 8'h00;
        send_msg(K, 1);
        drain();
        chk("zero_parity", 64'(hist[31:0]), 64'h0);

        msg_buf[K-1] = 8'h01;
        model_parity(K);
        chk("model_pin", 64'({par_exp[0], par_exp[1], par_exp[2], par_exp[3]}),
            64'h0F367840);
        send_msg(K, 1);
        drain();
        chk("unit_parity", 64'(hist[31:0]), 64'h0F367840);

        gap_en   = 1;
        rdy_rand = 1;
        repeat (4) begin
            fill_rand(K);
            send_msg(K, 1);
        end
        drain();
        gap_en   = 0;
        rdy_rand = 0;
        repeat (2) @(negedge clk);

        fill_rand(30);
        msg_buf[29] = 8'hA5;
        send_msg(30, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_m_valid", 64'(m_valid), 64'd0);
        chk("mid_rst_m_data",  64'(m_data),  64'd0);
        chk("mid_rst_s_ready", 64'(s_ready), 64'd0);
        exp_q.delete();
        len_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fill_rand(K);
        send_msg(K, 1);
        drain();

        lc.delete();
        lowcnt = 0;
        tp_en  = 1;
        repeat (3) begin
            fill_rand(K);
            send_msg(K, 1);
        end
        drain();
        tp_en = 0;
        chk("tp_cw_count", 64'(lc.size()), 64'd3);
        chk("tp_period_1", 64'(lc[1] - lc[0]), 64'(K + NP));
        chk("tp_period_2", 64'(lc[2] - lc[1]), 64'(K + NP));
        chk("tp_ready_low", 64'(lowcnt), 64'(2 * NP));

`ifdef RS_ENC_SHORTEN_EN
        msg_buf[0] = 8'h01;
        send_msg(1, 1);
        drain();
        chk("short_unit", 64'(hist), 64'h010F367840);
`endif

        chk("final_queue", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
